// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV32M funct3
// codes, FSM state encoding and the minimum signed operand constant.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Most negative value at 64 bits; narrower widths take the top slice.
  localparam logic [63:0] MIN_SIGNED_64 = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module mdu_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvd_bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0]   shifted;
  logic [W-1:0] sub;

  assign shifted = {rem_i, dvd_bit_i};
  // The true difference is below 2^W whenever it is kept, so W bits suffice.
  assign sub     = shifted[W-1:0] - dvs_i;

  // Keep the difference when the divisor fits, otherwise restore.
  always_comb begin
    if (shifted >= {1'b0, dvs_i}) begin
      rem_o   = sub;
      q_bit_o = 1'b1;
    end else begin
      rem_o   = shifted[W-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with a valid/ready request side and a
// one-cycle done pulse. Define MDU_FAST_MUL_EN to route multiplies through a
// single-cycle signed multiplier instead of the shift-add loop.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MDU_VALID_i,
  input  logic [2:0]      MDU_OP_i,
  input  logic [XLEN-1:0] MDU_RS1_i,
  input  logic [XLEN-1:0] MDU_RS2_i,
  output logic            MDU_READY_o,
  output logic            MDU_DONE_o,
  output logic [XLEN-1:0] MDU_RD_o,
  output logic            MDU_DZ_o
);

  localparam int unsigned    CW       = $clog2(XLEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_S   = MIN_SIGNED_64[63 -: XLEN];

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand or divisor
  logic [XLEN-1:0] hi_q, hi_d;       // product high half or partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier/product low half or dividend/quotient
  logic            sa_q, sa_d;       // rs1 is negative under its signedness
  logic            sb_q, sb_d;       // rs2 is negative under its signedness
  logic            zdiv_q, zdiv_d;
  logic            ovf_q, ovf_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            dz_q, dz_d;

  logic            rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_rem;
  logic            div_qbit;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;

  assign rs1_signed = (MDU_OP_i == OP_MULH) || (MDU_OP_i == OP_MULHSU) ||
                      (MDU_OP_i == OP_DIV)  || (MDU_OP_i == OP_REM);
  assign rs2_signed = (MDU_OP_i == OP_MULH) || (MDU_OP_i == OP_DIV) ||
                      (MDU_OP_i == OP_REM);
  assign rs1_neg    = rs1_signed & MDU_RS1_i[XLEN-1];
  assign rs2_neg    = rs2_signed & MDU_RS2_i[XLEN-1];
  assign abs1       = rs1_neg ? -MDU_RS1_i : MDU_RS1_i;
  assign abs2       = rs2_neg ? -MDU_RS2_i : MDU_RS2_i;

  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};

  mdu_div_step #(.W(XLEN)) u_div_step (
    .rem_i     (hi_q),
    .dvd_bit_i (lo_q[XLEN-1]),
    .dvs_i     (opnd_q),
    .rem_o     (div_rem),
    .q_bit_o   (div_qbit)
  );

`ifdef MDU_FAST_MUL_EN
  // Raw operands are held in opnd/lo; sa/sb double as the extension bits.
  logic signed [2*XLEN+1:0] prod_full;
  assign prod_full = $signed({sa_q, opnd_q}) * $signed({sb_q, lo_q});
  assign prod      = prod_full[2*XLEN-1:0];
`else
  assign prod = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
`endif

  assign quo = zdiv_q ? '1 : (ovf_q ? MIN_S : ((sa_q ^ sb_q) ? -lo_q : lo_q));
  assign rem = ovf_q ? '0 : (sa_q ? -hi_q : hi_q);

  // Next-state, datapath iteration and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zdiv_d  = zdiv_q;
    ovf_d   = ovf_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    rd_d    = rd_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (MDU_VALID_i) begin
          op_d    = MDU_OP_i;
          cnt_d   = '0;
          hi_d    = '0;
          ready_d = 1'b0;
          sa_d    = rs1_neg;
          sb_d    = rs2_neg;
          zdiv_d  = MDU_OP_i[2] && (MDU_RS2_i == '0);
          ovf_d   = MDU_OP_i[2] && rs2_signed && (MDU_RS1_i == MIN_S) && (MDU_RS2_i == '1);
          state_d = CALC;
          if (MDU_OP_i[2]) begin
            opnd_d = abs2;
            lo_d   = abs1;
          end else begin
`ifdef MDU_FAST_MUL_EN
            opnd_d  = MDU_RS1_i;
            lo_d    = MDU_RS2_i;
            state_d = FIX;
`else
            opnd_d = abs1;
            lo_d   = abs2;
`endif
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          hi_d = div_rem;
          lo_d = {lo_q[XLEN-2:0], div_qbit};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        case (op_q)
          OP_MUL:                       rd_d = prod[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: rd_d = prod[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              rd_d = quo;
          default:                      rd_d = rem;
        endcase
        dz_d    = zdiv_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zdiv_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rd_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      zdiv_q  <= zdiv_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      dz_q    <= dz_d;
    end
  end

  assign MDU_READY_o = ready_q;
  assign MDU_DONE_o  = done_q;
  assign MDU_RD_o    = rd_q;
  assign MDU_DZ_o    = dz_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit executing the RV32M operation set alongside the combinational `Alu` in the processor execute stage. Parametrised in operand width, it accepts one operation through a valid/ready handshake and returns a 1-cycle done pulse with the result held stable afterwards. The pipeline stalls on `MDU_READY_o` low. Division corner cases follow the RISC-V M specification exactly.

## Interface
- `XLEN`, 32: operand and result width; must be even and ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous to `clk`, active-high.
- `MDU_VALID_i`  in  1  request strobe; sampled only when `MDU_READY_o` = 1.
- `MDU_OP_i`  in  3  operation, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `MDU_RS1_i`  in  XLEN  multiplicand or dividend.
- `MDU_RS2_i`  in  XLEN  multiplier or divisor.
- `MDU_READY_o`  out  1  unit idle; can accept a request this cycle.
- `MDU_DONE_o`  out  1  1-cycle pulse; `MDU_RD_o` is valid.
- `MDU_RD_o`  out  XLEN  result; holds its value until the next DONE.
- `MDU_DZ_o`  out  1  divide-by-zero flag; qualified by DONE.

## Operation
- FSM states: IDLE → CALC → FIX → DONE → IDLE.
  - IDLE: READY = 1. On VALID, latch op and operands, take absolute values according to signedness, clear the iteration counter, and go to CALC.
  - CALC: exactly XLEN iterations, one per cycle.
    - Multiply: shift-add into a 2·XLEN accumulator.
    - Divide: restoring shift-subtract, producing quotient and remainder registers.
    - Go to FIX when the counter reaches XLEN−1.
  - FIX: apply sign correction, then select the result.
    - MUL: low half. MULH/MULHSU/MULHU: high half.
    - DIV/DIVU: quotient. REM/REMU: remainder.
    - Go to DONE.
  - DONE: DONE = 1 for one cycle; `MDU_RD_o` and `MDU_DZ_o` update in this cycle; READY = 0. Go to IDLE.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: RS1 signed, RS2 unsigned.
  - All other ops unsigned.
  - Result negation: product when the operand signs differ; quotient when signs differ; remainder takes the dividend's sign.
- Division by zero: quotient = all ones; remainder = RS1 unchanged; `MDU_DZ_o` = 1. Latency is unchanged.
- Signed overflow (RS1 = −2^(XLEN−1), RS2 = −1): DIV returns RS1; REM returns 0; `MDU_DZ_o` = 0.
- VALID while READY = 0 is ignored; no request is queued.
- Input operands are needed only in the accept cycle and may change afterwards.

## Timing
- Reset values: READY = 1, DONE = 0, `MDU_RD_o` = 0, `MDU_DZ_o` = 0; FSM = IDLE; counter = 0.
- With acceptance in cycle N, DONE is high in cycle N+XLEN+2 (34 for XLEN = 32) for every op.
- READY returns to 1 in cycle N+XLEN+3.
- Back-to-back throughput: one op per XLEN+3 cycles.
- Reset asserted during CALC or FIX aborts the operation. No DONE is produced, outputs take their reset values on the next edge, and READY = 1 in the first cycle after `rst` deasserts.
- VALID and `rst` high together: reset wins and the request is dropped.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - Multiply ops bypass CALC: IDLE → FIX, with the product formed in FIX by a single (XLEN+1)×(XLEN+1) signed `*` on sign- or zero-extended operands.
  - Multiply DONE falls at N+2 and READY returns at N+3.
  - Divide ops are unchanged.
- Not defined: all ops are iterative with uniform latency XLEN+2. No DSP multiplier is inferred.

## Structure
- Shared package `mdu_pkg`:
  - funct3 op localparams.
  - FSM state encoding: IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3.
  - Helper constant for the minimum signed value.
- One natural sub-module: `mdu_div_step`, a combinational single restoring-division step (partial remainder, divisor → next partial remainder, quotient bit).
- The multiply iteration stays inline.

## Test plan
- MUL, 7 × −3 (0xFFFFFFFD) → `MDU_RD_o` = 0xFFFFFFEB; DONE exactly at N+34; READY low from N+1 to N+34.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF with DZ = 1; REM 5 / 0 → 5 with DZ = 1; DIV 0x80000000 / −1 → 0x80000000; REM of the same → 0.
- Assert `rst` at N+10 of a DIV → no DONE pulse, `MDU_RD_o` = 0, READY = 1 in the cycle after `rst` falls; a new request is then accepted normally.
- VALID held high during busy with changing operands → only the first request executes. With `MDU_FAST_MUL_EN`: MUL 6 × 7 → 42 with DONE at N+2.
